// File: rtl/ps2_letter_input.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_letter_input: PS/2 frame receiver, A-Z make codes to one-clock ASCII pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module ps2_letter_input #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] user_input,
  output logic       key_valid,
  output logic       frame_error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic [1:0]             state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   stop_q, stop_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   brk_q, brk_d;
  logic                   ext_q, ext_d;
  logic [7:0]             user_input_q, user_input_d;
  logic                   key_valid_q, key_valid_d;
  logic                   frame_error_q, frame_error_d;

  logic       ps2_clk_s, ps2_data_s, fall;
  logic [7:0] ascii;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
    case (sc)
      8'h1C: scan_to_ascii = 8'h41;  8'h32: scan_to_ascii = 8'h42;
      8'h21: scan_to_ascii = 8'h43;  8'h23: scan_to_ascii = 8'h44;
      8'h24: scan_to_ascii = 8'h45;  8'h2B: scan_to_ascii = 8'h46;
      8'h34: scan_to_ascii = 8'h47;  8'h33: scan_to_ascii = 8'h48;
      8'h43: scan_to_ascii = 8'h49;  8'h3B: scan_to_ascii = 8'h4A;
      8'h42: scan_to_ascii = 8'h4B;  8'h4B: scan_to_ascii = 8'h4C;
      8'h3A: scan_to_ascii = 8'h4D;  8'h31: scan_to_ascii = 8'h4E;
      8'h44: scan_to_ascii = 8'h4F;  8'h4D: scan_to_ascii = 8'h50;
      8'h15: scan_to_ascii = 8'h51;  8'h2D: scan_to_ascii = 8'h52;
      8'h1B: scan_to_ascii = 8'h53;  8'h2C: scan_to_ascii = 8'h54;
      8'h3C: scan_to_ascii = 8'h55;  8'h2A: scan_to_ascii = 8'h56;
      8'h1D: scan_to_ascii = 8'h57;  8'h22: scan_to_ascii = 8'h58;
      8'h35: scan_to_ascii = 8'h59;  8'h1A: scan_to_ascii = 8'h5A;
      default: scan_to_ascii = 8'h00;
    endcase
  endfunction

  assign ascii = scan_to_ascii(shift_q);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    stop_d        = stop_q;
    tmo_d         = tmo_q;
    brk_d         = brk_q;
    ext_d         = ext_q;
    user_input_d  = 8'h00;
    key_valid_d   = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d     = '0;
        bit_cnt_d = 4'd0;
        if (fall) begin
          if (!ps2_data_s) state_d = RECV;
          else             frame_error_d = 1'b1;
        end
      end
      RECV: begin
        // An edge always wins over a timeout landing on the same clock
        if (fall) begin
          tmo_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            shift_d = {ps2_data_s, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            parity_d = ps2_data_s;
          end else begin
            stop_d  = ps2_data_s;
            state_d = DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_error_d = 1'b1;
          tmo_d         = '0;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        tmo_d   = '0;
        if (!(^{shift_q, parity_q}) || !stop_q) begin
          frame_error_d = 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (shift_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (brk_q || ext_q) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else if (ascii != 8'h00) begin
          user_input_d = ascii;
          key_valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q    <= '1;
      data_sync_q   <= '1;
      clk_prev_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      stop_q        <= 1'b0;
      tmo_q         <= '0;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      user_input_q  <= 8'h00;
      key_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      clk_sync_q    <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q    <= ps2_clk_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      stop_q        <= stop_d;
      tmo_q         <= tmo_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      user_input_q  <= user_input_d;
      key_valid_q   <= key_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign user_input  = user_input_q;
  assign key_valid   = key_valid_q;
  assign frame_error = frame_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_letter_input.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_letter_input: directed PS/2 frames against hand-computed ASCII results
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ps2_letter_input;

  localparam int TMO  = 200;
  localparam int SYNC = 2;
  localparam int HP   = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] user_input;
  logic       key_valid;
  logic       frame_error;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int kv_cnt = 0, fe_cnt = 0, kv_cyc = 0, fe_cyc = 0;
  int kv_incons = 0, kv_long = 0, fe_long = 0;
  logic [7:0] last_ascii = 8'h00;
  logic prev_kv = 1'b0, prev_fe = 1'b0;
  int last_fall_cyc = 0;
  int base_kv, base_fe;

  ps2_letter_input #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .user_input(user_input), .key_valid(key_valid), .frame_error(frame_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (key_valid) begin
      kv_cnt++;
      kv_cyc = cyc;
      last_ascii = user_input;
    end
    if (frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (key_valid !== (user_input != 8'h00)) kv_incons++;
    if (key_valid && prev_kv) kv_long++;
    if (frame_error && prev_fe) fe_long++;
    prev_kv = key_valid;
    prev_fe = frame_error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    ps2_data = b;
    wait_clk(HP);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_clk(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(stop);
    @(negedge clock);
    ps2_data = 1'b1;
    wait_clk(2 * HP);
  endtask

  task automatic snap;
    base_kv = kv_cnt;
    base_fe = fe_cnt;
  endtask

  initial begin
    wait_clk(3);
    #1;
    check("reset_user_input", {24'h0, user_input}, 32'h0);
    check("reset_key_valid", {31'h0, key_valid}, 32'h0);
    check("reset_frame_error", {31'h0, frame_error}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_clk(5);

    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t1_pulses", kv_cnt - base_kv, 1);
    check("t1_ascii", {24'h0, last_ascii}, 32'h41);
    check("t1_latency", kv_cyc - last_fall_cyc, SYNC + 2);
    check("t1_no_err", fe_cnt - base_fe, 0);

    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t2_pulses", kv_cnt - base_kv, 1);
    check("t2_ascii", {24'h0, last_ascii}, 32'h41);

    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check("t3_no_pulse", kv_cnt - base_kv, 0);
    check("t3_no_err", fe_cnt - base_fe, 0);

    snap();
    send_frame(8'h1A, 1'b1, 1'b1);
    check("t4_parity_err", fe_cnt - base_fe, 1);
    check("t4_no_pulse", kv_cnt - base_kv, 0);
    send_frame(8'h1A, 1'b0, 1'b1);
    check("t4_recover_pulses", kv_cnt - base_kv, 1);
    check("t4_recover_ascii", {24'h0, last_ascii}, 32'h5A);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(TMO + 50);
    check("t5_timeout_err", fe_cnt - base_fe, 1);
    check("t5_timeout_delay", fe_cyc - last_fall_cyc, SYNC + 1 + TMO);
    check("t5_no_pulse", kv_cnt - base_kv, 0);
    send_frame(8'h2D, 1'b0, 1'b1);
    check("t5_recover_ascii", {24'h0, last_ascii}, 32'h52);
    check("t5_recover_pulses", kv_cnt - base_kv, 1);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t6_rst_user_input", {24'h0, user_input}, 32'h0);
    check("t6_rst_key_valid", {31'h0, key_valid}, 32'h0);
    check("t6_rst_frame_error", {31'h0, frame_error}, 32'h0);
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(5);
    send_frame(8'h35, 1'b0, 1'b1);
    check("t6_recover_ascii", {24'h0, last_ascii}, 32'h59);
    check("t6_recover_pulses", kv_cnt - base_kv, 1);
    check("t6_no_err", fe_cnt - base_fe, 0);

    snap();
    send_frame(8'h2C, 1'b0, 1'b1);
    send_frame(8'h2C, 1'b0, 1'b1);
    check("typematic_pulses", kv_cnt - base_kv, 2);
    check("typematic_ascii", {24'h0, last_ascii}, 32'h54);

    snap();
    send_frame(8'h16, 1'b0, 1'b1);
    check("unmapped_no_pulse", kv_cnt - base_kv, 0);
    check("unmapped_no_err", fe_cnt - base_fe, 0);

    snap();
    send_frame(8'h32, 1'b0, 1'b0);
    check("stop_err", fe_cnt - base_fe, 1);
    check("stop_no_pulse", kv_cnt - base_kv, 0);

    snap();
    send_bit(1'b1);
    wait_clk(2 * HP);
    check("start_err", fe_cnt - base_fe, 1);
    send_frame(8'h32, 1'b0, 1'b1);
    check("start_recover_ascii", {24'h0, last_ascii}, 32'h42);

    check("kv_consistency", kv_incons, 0);
    check("kv_one_clock", kv_long, 0);
    check("fe_one_clock", fe_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
